// File: rtl/adventure_driver.sv
// rtl/adventure_driver.sv - route player that drives the room-navigation FSM and checks each move
module adventure_driver #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       skip_sword,
  input  logic [6:0] room,
  input  logic       sw_in,
  input  logic       win_in,
  input  logic       d_in,
  output logic       n,
  output logic       s,
  output logic       e,
  output logic       w,
  output logic       v,
  output logic       busy,
  output logic       done,
  output logic       won,
  output logic       died,
  output logic       fail,
  output logic [1:0] fail_code,
  output logic [2:0] step
);

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE, ST_FAIL} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] cmd_q, cmd_d;          // {n, s, e, w}
  logic [6:0] pre_q, pre_d;          // room seen when the move was issued
  logic [7:0] timer_q, timer_d;
  logic [2:0] step_q, step_d;
  logic [1:0] code_q, code_d;
  logic       sword_q, sword_d;
  logic       skip_q, skip_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       won_q, won_d;
  logic       died_q, died_d;
  logic       fail_q, fail_d;
  logic       timeout;
  logic       flag_ok;
  logic       flag_bad;

  // Command for each route step as {n, s, e, w}; step 5 only watches the outcome flags.
  function automatic logic [3:0] cmd_of(input logic [2:0] st);
    case (st)
      3'd0:    cmd_of = 4'b0010;
      3'd1:    cmd_of = 4'b0100;
      3'd2:    cmd_of = 4'b0001;
      3'd3:    cmd_of = 4'b0010;
      3'd4:    cmd_of = 4'b0110;
      default: cmd_of = 4'b0000;
    endcase
  endfunction

  // Room the FSM should land in after each move.
  function automatic logic [6:0] exp_of(input logic [2:0] st);
    case (st)
      3'd0:    exp_of = 7'b0000010;
      3'd1:    exp_of = 7'b0000100;
      3'd2:    exp_of = 7'b0001000;
      3'd3:    exp_of = 7'b0000100;
      3'd4:    exp_of = 7'b0010000;
      default: exp_of = 7'b0000000;
    endcase
  endfunction

  // Skipping the sword detour jumps from step 1 straight to the room-4 move.
  function automatic logic [2:0] next_of(input logic [2:0] st, input logic sk);
    if (st == 3'd1 && sk) next_of = 3'd4;
    else                  next_of = st + 3'd1;
  endfunction

  assign timeout  = (timer_q == TIMER_LAST);
  assign flag_ok  = sword_q ? win_in : d_in;
  assign flag_bad = sword_q ? d_in : win_in;

  // Next-state and next-output logic; command bits default low so pulses last one cycle.
  always_comb begin
    state_d = state_q;
    cmd_d   = 4'b0000;
    pre_d   = pre_q;
    timer_d = timer_q;
    step_d  = step_q;
    code_d  = code_q;
    sword_d = sword_q;
    skip_d  = skip_q;
    busy_d  = busy_q;
    done_d  = done_q;
    won_d   = won_q;
    died_d  = died_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          done_d  = 1'b0;
          won_d   = 1'b0;
          died_d  = 1'b0;
          fail_d  = 1'b0;
          code_d  = 2'd0;
          skip_d  = skip_sword;
          sword_d = 1'b0;
          step_d  = 3'd0;
          if (room != 7'b0000001) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            code_d  = 2'd1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_ISSUE;
            busy_d  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        cmd_d   = cmd_of(step_q);
        pre_d   = room;
        timer_d = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (step_q == 3'd2 && sw_in) sword_d = 1'b1;
        if (step_q < 3'd5) begin
          if (room == exp_of(step_q)) begin
            step_d  = next_of(step_q, skip_q);
            state_d = ST_ISSUE;
          end else if (room != pre_q) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            code_d  = 2'd3;
            busy_d  = 1'b0;
          end else if (timeout) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            code_d  = 2'd2;
            busy_d  = 1'b0;
          end
        end else begin
          if (flag_ok) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            won_d   = win_in;
            died_d  = d_in;
          end else if (flag_bad || timeout) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            code_d  = flag_bad ? 2'd3 : 2'd2;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears everything, dropping commands immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= 4'b0000;
      pre_q   <= 7'b0000000;
      timer_q <= 8'd0;
      step_q  <= 3'd0;
      code_q  <= 2'd0;
      sword_q <= 1'b0;
      skip_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      won_q   <= 1'b0;
      died_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      pre_q   <= pre_d;
      timer_q <= timer_d;
      step_q  <= step_d;
      code_q  <= code_d;
      sword_q <= sword_d;
      skip_q  <= skip_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      won_q   <= won_d;
      died_q  <= died_d;
      fail_q  <= fail_d;
    end
  end

  assign {n, s, e, w} = cmd_q;
  assign v         = sword_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign won       = won_q;
  assign died      = died_q;
  assign fail      = fail_q;
  assign fail_code = code_q;
  assign step      = step_q;

endmodule

// File: tb/tb_adventure_driver.sv
// tb/tb_adventure_driver.sv - scoreboard bench for adventure_driver against a behavioural room FSM
module tb_adventure_driver;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       skip_sword = 1'b0;
  logic [6:0] room_in;
  logic       sw_in, win_in, d_in;
  logic       n, s, e, w, v, busy, done, won, died, fail;
  logic [1:0] fail_code;
  logic [2:0] step;

  // room model controls
  logic [6:0] room_m;
  logic       mrst = 1'b0;
  logic       freeze = 1'b0;
  logic       jump = 1'b0;
  logic       force_en = 1'b0;
  logic [6:0] force_val = 7'b0000000;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int cmd_cnt = 0;
  int last_cmd_cyc = 0;
  int v_rises = 0;
  logic [3:0] exp_q[$];
  logic [3:0] prev_cmd = 4'b0000;
  logic       prev_v = 1'b0;
  logic [2:0] prev_step = 3'd0;

  adventure_driver #(.TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .skip_sword(skip_sword),
    .room(room_in), .sw_in(sw_in), .win_in(win_in), .d_in(d_in),
    .n(n), .s(s), .e(e), .w(w), .v(v), .busy(busy), .done(done),
    .won(won), .died(died), .fail(fail), .fail_code(fail_code), .step(step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign room_in = force_en ? force_val : room_m;
  assign sw_in   = room_m[3];
  assign win_in  = room_m[4] & v;
  assign d_in    = room_m[4] & ~v;

  // behavioural room FSM
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) room_m <= 7'b0000001;
    else if (mrst) room_m <= 7'b0000001;
    else begin
      case (room_m)
        7'b0000001: if (e) room_m <= 7'b0000010;
        7'b0000010: if (s) room_m <= jump ? 7'b0001000 : 7'b0000100;
        7'b0000100: begin
          if (s && e) room_m <= 7'b0010000;
          else if (w && !freeze) room_m <= 7'b0001000;
        end
        7'b0001000: if (e) room_m <= 7'b0000100;
        default: room_m <= room_m;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // command monitor: pops expected commands, checks pulse width and sword timing
  always @(negedge clk) begin
    logic [3:0] cmd;
    logic [3:0] ex;
    cmd = {n, s, e, w};
    if (reset_n) begin
      if (cmd != 4'b0000) begin
        cmd_cnt++;
        last_cmd_cyc = cyc;
        if (exp_q.size() == 0) chk("cmd_unexpected", {28'd0, cmd}, 32'd0);
        else begin
          ex = exp_q.pop_front();
          chk("cmd", {28'd0, cmd}, {28'd0, ex});
        end
        chk("pulse_width", {28'd0, prev_cmd}, 32'd0);
      end
      if (v && !prev_v) begin
        v_rises++;
        chk("v_rise_step", {29'd0, prev_step}, 32'd2);
      end
    end
    prev_cmd  = cmd;
    prev_v    = v;
    prev_step = step;
  end

  task automatic model_reset(input logic fz, input logic jp);
    @(negedge clk);
    mrst = 1'b1; freeze = fz; jump = jp;
    @(negedge clk);
    mrst = 1'b0;
  endtask

  task automatic do_start(input logic sk);
    @(negedge clk);
    skip_sword = sk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int k;
    k = 0;
    while (!(done || fail) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("end_reached", {31'd0, done | fail}, 32'd1);
  endtask

  task automatic push_win;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0110);
  endtask

  initial begin
    int t0;
    int vr0;
    int cc0;
    int k;
    // reset state
    #12;
    chk("reset_outputs", {18'd0, n, s, e, w, v, busy, done, won, died, fail, fail_code, step}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // full win route
    push_win();
    do_start(1'b0);
    t0 = cyc;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_end(40);
    chk("win_latency_le20", {31'd0, (cyc - t0) <= 20}, 32'd1);
    chk("win_done", {31'd0, done}, 32'd1);
    chk("win_won", {31'd0, won}, 32'd1);
    chk("win_died", {31'd0, died}, 32'd0);
    chk("win_code", {30'd0, fail_code}, 32'd0);
    chk("win_v", {31'd0, v}, 32'd1);
    chk("win_busy", {31'd0, busy}, 32'd0);
    chk("win_q_empty", exp_q.size(), 32'd0);

    // skip sword: death route
    model_reset(1'b0, 1'b0);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0110);
    vr0 = v_rises;
    do_start(1'b1);
    wait_end(40);
    chk("skip_done", {31'd0, done}, 32'd1);
    chk("skip_died", {31'd0, died}, 32'd1);
    chk("skip_won", {31'd0, won}, 32'd0);
    chk("skip_v", {31'd0, v}, 32'd0);
    chk("skip_no_v_rise", v_rises - vr0, 32'd0);
    chk("skip_q_empty", exp_q.size(), 32'd0);

    // room model ignores w: timeout in step 2
    model_reset(1'b1, 1'b0);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001);
    do_start(1'b0);
    wait_end(60);
    chk("to_fail", {31'd0, fail}, 32'd1);
    chk("to_code", {30'd0, fail_code}, 32'd2);
    chk("to_step", {29'd0, step}, 32'd2);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_cycles", cyc - last_cmd_cyc, T);
    chk("to_q_empty", exp_q.size(), 32'd0);

    // start outside room 0
    model_reset(1'b0, 1'b0);
    force_en = 1'b1;
    force_val = 7'b0000100;
    cc0 = cmd_cnt;
    do_start(1'b0);
    chk("r0_fail", {31'd0, fail}, 32'd1);
    chk("r0_code", {30'd0, fail_code}, 32'd1);
    chk("r0_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("r0_no_cmd", cmd_cnt - cc0, 32'd0);
    force_en = 1'b0;

    // wrong room after step-1 move
    model_reset(1'b0, 1'b1);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    do_start(1'b0);
    wait_end(40);
    chk("wr_fail", {31'd0, fail}, 32'd1);
    chk("wr_code", {30'd0, fail_code}, 32'd3);
    chk("wr_step", {29'd0, step}, 32'd1);
    chk("wr_q_empty", exp_q.size(), 32'd0);

    // reset mid step 3, then a clean win run
    model_reset(1'b0, 1'b0);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001);
    do_start(1'b0);
    k = 0;
    while (step != 3'd3 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reached_step3", {29'd0, step}, 32'd3);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {18'd0, n, s, e, w, v, busy, done, won, died, fail, fail_code, step}, 32'd0);
    chk("mid_q_empty", exp_q.size(), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    push_win();
    do_start(1'b0);
    wait_end(40);
    chk("rerun_done", {31'd0, done}, 32'd1);
    chk("rerun_won", {31'd0, won}, 32'd1);
    chk("rerun_code", {30'd0, fail_code}, 32'd0);
    chk("rerun_q_empty", exp_q.size(), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
